// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Holds FSM encoding, forward-select codes and instruction field positions.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } hz_state_t;

  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  localparam int REG_W = 5;

  function automatic logic [REG_W-1:0] rs_of(
    input logic [31:0] inst
  );
    return inst[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [REG_W-1:0] rt_of(
    input logic [31:0] inst
  );
    return inst[RT_MSB:RT_LSB];
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Forward-select for one ALU operand: EX/MEM beats MEM/WB, r0 never matches.
// Ports: src register, enable, EX/MEM and MEM/WB rd/write flags; sel out.
module fwd_select
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             en,
  input  logic [REG_W-1:0] exmem_rd,
  input  logic             exmem_wr,
  input  logic [REG_W-1:0] memwb_rd,
  input  logic             memwb_wr,
  output logic [1:0]       sel
);

  logic hit_exmem;
  logic hit_memwb;

  assign hit_exmem = exmem_wr
                  && (exmem_rd != '0)
                  && (exmem_rd == src);
  assign hit_memwb = memwb_wr
                  && (memwb_rd != '0)
                  && (memwb_rd == src);

  always_comb begin
    sel = FWD_NONE;
    if (en) begin
      if (hit_exmem)
        sel = FWD_EXMEM;
      else if (hit_memwb)
        sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: operand forwarding, load-use stall, branch flush.
// Ports: clk, rst_n, EX/ID insts and EX controls in; fwd selects,
// PC/IF-ID enables, bubble, flush and saturating event counters out.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      id_ex_inst,
  input  logic [31:0]      if_id_inst,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_uses_rt,
  input  logic             branch_taken,
  output logic [1:0]       fwd_ctrl_a,
  output logic [1:0]       fwd_ctrl_b,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [REG_W-1:0] exmem_rd;
  logic             exmem_wr;
  logic [REG_W-1:0] memwb_rd;
  logic             memwb_wr;

  hz_state_t state;
  hz_state_t state_nxt;

  logic load_use;
  logic stall_evt;
  logic flush_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exmem_rd <= '0;
      exmem_wr <= 1'b0;
      memwb_rd <= '0;
      memwb_wr <= 1'b0;
    end else begin
      exmem_rd <= ex_rd;
      exmem_wr <= ex_reg_write;
      memwb_rd <= exmem_rd;
      memwb_wr <= exmem_wr;
    end
  end

  fwd_select u_fwd_a (
    .src      (rs_of(id_ex_inst)),
    .en       (1'b1),
    .exmem_rd (exmem_rd),
    .exmem_wr (exmem_wr),
    .memwb_rd (memwb_rd),
    .memwb_wr (memwb_wr),
    .sel      (fwd_ctrl_a)
  );

  fwd_select u_fwd_b (
    .src      (rt_of(id_ex_inst)),
    .en       (ex_uses_rt),
    .exmem_rd (exmem_rd),
    .exmem_wr (exmem_wr),
    .memwb_rd (memwb_rd),
    .memwb_wr (memwb_wr),
    .sel      (fwd_ctrl_b)
  );

  assign load_use = ex_mem_read
                 && (ex_rd != '0)
                 && ((ex_rd == rs_of(if_id_inst))
                  || (ex_rd == rt_of(if_id_inst)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_RUN;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = ST_RUN;
    unique case (state)
      ST_RUN: begin
        if (branch_taken)
          state_nxt = ST_FLUSH;
        else if (load_use)
          state_nxt = ST_STALL;
      end
      ST_STALL: begin
        if (branch_taken)
          state_nxt = ST_FLUSH;
      end
      ST_FLUSH: state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // Events are masked while reset is held so the outputs read
  // as a free-running pipeline regardless of the inputs.
  always_comb begin
    stall_evt = 1'b0;
    flush_evt = 1'b0;
    if (rst_n) begin
      unique case (state)
        ST_RUN: begin
          flush_evt = branch_taken;
          stall_evt = !branch_taken && load_use;
        end
        ST_STALL: flush_evt = branch_taken;
        ST_FLUSH: flush_evt = 1'b0;
        default:  flush_evt = 1'b0;
      endcase
    end
  end

  always_comb begin
    pc_write     = !stall_evt;
    if_id_write  = !stall_evt;
    id_ex_bubble = stall_evt || flush_evt;
    if_id_flush  = flush_evt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_evt && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_evt && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
